// File: rtl/fb_vga_pkg.sv
// fb_vga_pkg: shared timing constants and pixel types for the VGA block.
//   H_* boundaries are in 50 MHz clocks (two clocks per pixel), V_* in lines.
//   rgb_t     : packed {r,g,b} pixel, 8 bits per channel.
//   bar_color : colour-bar generator used by the optional test pattern.
package fb_vga_pkg;

  localparam logic [10:0] H_ACTIVE   = 11'd1280;
  localparam logic [10:0] H_FP_END   = 11'd1312;
  localparam logic [10:0] H_SYNC_END = 11'd1504;
  localparam logic [10:0] H_TOTAL    = 11'd1600;

  localparam logic [9:0]  V_ACTIVE   = 10'd480;
  localparam logic [9:0]  V_FP_END   = 10'd490;
  localparam logic [9:0]  V_SYNC_END = 10'd492;
  localparam logic [9:0]  V_TOTAL    = 10'd525;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    BAR_WHITE,
    BAR_YELLOW,
    BAR_CYAN,
    BAR_GREEN,
    BAR_MAGENTA,
    BAR_RED,
    BAR_BLUE,
    BAR_BLACK
  } bar_t;

  // Bars are 80 columns wide so the eight of them span the full 640-pixel line.
  function automatic rgb_t bar_color(input logic [9:0] col);
    bar_t idx;
    rgb_t c;
    if      (col < 10'd80)  idx = BAR_WHITE;
    else if (col < 10'd160) idx = BAR_YELLOW;
    else if (col < 10'd240) idx = BAR_CYAN;
    else if (col < 10'd320) idx = BAR_GREEN;
    else if (col < 10'd400) idx = BAR_MAGENTA;
    else if (col < 10'd480) idx = BAR_RED;
    else if (col < 10'd560) idx = BAR_BLUE;
    else                    idx = BAR_BLACK;
    case (idx)
      BAR_WHITE:   c = rgb_t'(24'hFFFFFF);
      BAR_YELLOW:  c = rgb_t'(24'hFFFF00);
      BAR_CYAN:    c = rgb_t'(24'h00FFFF);
      BAR_GREEN:   c = rgb_t'(24'h00FF00);
      BAR_MAGENTA: c = rgb_t'(24'hFF00FF);
      BAR_RED:     c = rgb_t'(24'hFF0000);
      BAR_BLUE:    c = rgb_t'(24'h0000FF);
      default:     c = rgb_t'(24'h000000);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fb_delay_line.sv
// fb_delay_line: DEPTH-stage shift register, WIDTH bits wide.
//   clk, reset : clock, asynchronous active-high reset (all stages -> RESET_VAL)
//   din        : value entering the line
//   dout       : din delayed by DEPTH clocks
module fb_delay_line #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fb_vga_timing.sv
// fb_vga_timing: 640x480@60 Hz VGA timing from the 50 MHz clock.
//   clk, reset      : 50 MHz clock, asynchronous active-high reset
//   pix_rgb         : {R,G,B} from the pixel source, LATENCY clocks after request
//   test_mode       : select internal colour bars (FB_VGA_TEST_PATTERN_EN builds only)
//   req_x/req_y     : requested column/row, combinational from the counters
//   req_valid       : request lies inside the active area
//   VGA_*           : DE1-SoC DAC pins, LATENCY+1 clocks behind the counters
//   vblank_start    : one-clock pulse on entry to vertical blanking
//   frame_count     : completed frames, wraps
// Optional feature: define FB_VGA_TEST_PATTERN_EN to build the colour-bar generator.
module fb_vga_timing
  import fb_vga_pkg::*;
#(
  parameter int unsigned LATENCY = 2  // legal 1..8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] pix_rgb,
  input  logic        test_mode,
  output logic [9:0]  req_x,
  output logic [9:0]  req_y,
  output logic        req_valid,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        raw_hs, raw_vs, raw_blank;
  logic [3:0]  sync_d;   // {hs, vs, blank, hcount[0]} after LATENCY clocks
  logic        blank_d;
  logic        vb_hit;
  rgb_t        rgb_next, rgb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_TOTAL - 11'd1) begin
      hcount <= '0;
      vcount <= (vcount == V_TOTAL - 10'd1) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  assign raw_hs    = !(hcount >= H_FP_END && hcount < H_SYNC_END);
  assign raw_vs    = !(vcount >= V_FP_END && vcount < V_SYNC_END);
  assign raw_blank = (hcount >= H_ACTIVE) || (vcount >= V_ACTIVE);

  assign req_x     = hcount[10:1];
  assign req_y     = vcount;
  assign req_valid = !raw_blank;

  // Syncs, blank and the half-pixel clock travel together so they stay
  // aligned with RGB returned by the fixed-latency source.
  fb_delay_line #(
    .WIDTH     (4),
    .DEPTH     (LATENCY),
    .RESET_VAL (4'b1110)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .din   ({raw_hs, raw_vs, raw_blank, hcount[0]}),
    .dout  (sync_d)
  );

  assign blank_d = sync_d[1];

`ifdef FB_VGA_TEST_PATTERN_EN
  logic [9:0] col_d;

  fb_delay_line #(
    .WIDTH     (10),
    .DEPTH     (LATENCY),
    .RESET_VAL ('0)
  ) u_col_dly (
    .clk   (clk),
    .reset (reset),
    .din   (hcount[10:1]),
    .dout  (col_d)
  );
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  always_comb begin
    rgb_next = rgb_t'(pix_rgb);
`ifdef FB_VGA_TEST_PATTERN_EN
    if (test_mode) rgb_next = bar_color(col_d);
`endif
    if (blank_d) rgb_next = '0;
  end

  assign vb_hit = (hcount == '0) && (vcount == V_ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VGA_HS       <= 1'b1;
      VGA_VS       <= 1'b1;
      VGA_BLANK_N  <= 1'b0;
      VGA_CLK      <= 1'b0;
      rgb_q        <= '0;
      vblank_start <= 1'b0;
      frame_count  <= '0;
    end else begin
      VGA_HS       <= sync_d[3];
      VGA_VS       <= sync_d[2];
      VGA_BLANK_N  <= !blank_d;
      VGA_CLK      <= sync_d[0];
      rgb_q        <= rgb_next;
      vblank_start <= vb_hit;
      if (vb_hit) frame_count <= frame_count + 16'd1;
    end
  end

  assign VGA_R      = rgb_q.r;
  assign VGA_G      = rgb_q.g;
  assign VGA_B      = rgb_q.b;
  assign VGA_SYNC_N = 1'b0;

endmodule
